// File: rtl/program_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
`timescale 1ns/1ps
interface program_loader_if #(
  parameter int ADDR_W = 5
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/program_loader.sv
// Length-prefixed, little-endian byte-stream writer for the CPU instruction memory.
// Optional trailing XOR checksum byte when PROGRAM_LOADER_CHECKSUM_EN is defined.
`timescale 1ns/1ps
module program_loader #(
  parameter int WORDS  = 32,
  parameter int ADDR_W = $clog2(WORDS)
) (
  input  logic              clk,
  input  logic              reset_n,
  program_loader_if.slave   bus,
  output logic              cpu_reset,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    CHECK = 3'd2,
`endif
    DONE  = 3'd3,
    ERROR = 3'd4
  } state_t;

  localparam logic [8:0] WORDS_C = 9'(WORDS);

  state_t            state_r;
  logic [ADDR_W:0]   count_r;
  logic [1:0]        byte_idx_r;
  logic [ADDR_W-1:0] word_idx_r;
  logic [31:0]       word_r;
  logic              in_ready_r;
  logic              mem_we_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [31:0]       mem_wdata_r;
  logic              cpu_reset_r;
  logic              done_r;
  logic              error_r;
  logic [ADDR_W:0]   words_loaded_r;
  logic              xfer_s;
  logic              last_word_s;
  logic [31:0]       next_word_s;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]        csum_r;

  function automatic logic [7:0] csum_next(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction
`endif

  assign xfer_s      = bus.in_valid && in_ready_r;
  assign last_word_s = ({1'b0, word_idx_r} == (count_r - {{ADDR_W{1'b0}}, 1'b1}));
  // Bytes shift in from the top so the first byte ends up in bits [7:0].
  assign next_word_s = {bus.in_data, word_r[31:8]};

  // Loader state machine with all outputs registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r        <= IDLE;
      count_r        <= '0;
      byte_idx_r     <= 2'd0;
      word_idx_r     <= '0;
      word_r         <= 32'd0;
      in_ready_r     <= 1'b0;
      mem_we_r       <= 1'b0;
      mem_addr_r     <= '0;
      mem_wdata_r    <= 32'd0;
      cpu_reset_r    <= 1'b1;
      done_r         <= 1'b0;
      error_r        <= 1'b0;
      words_loaded_r <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum_r         <= 8'd0;
`endif
    end else begin
      mem_we_r <= 1'b0;
      case (state_r)
        IDLE: begin
          in_ready_r <= 1'b1;
          if (xfer_s) begin
            if ((bus.in_data == 8'd0) || ({1'b0, bus.in_data} > WORDS_C)) begin
              state_r    <= ERROR;
              in_ready_r <= 1'b0;
              error_r    <= 1'b1;
            end else begin
              state_r    <= LOAD;
              count_r    <= bus.in_data[ADDR_W:0];
              byte_idx_r <= 2'd0;
              word_idx_r <= '0;
            end
          end
        end
        LOAD: begin
          if (xfer_s) begin
            word_r     <= next_word_s;
            byte_idx_r <= byte_idx_r + 2'd1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum_r     <= csum_next(csum_r, bus.in_data);
`endif
            if (byte_idx_r == 2'd3) begin
              mem_we_r       <= 1'b1;
              mem_addr_r     <= word_idx_r;
              mem_wdata_r    <= next_word_s;
              words_loaded_r <= words_loaded_r + {{ADDR_W{1'b0}}, 1'b1};
              word_idx_r     <= word_idx_r + {{(ADDR_W-1){1'b0}}, 1'b1};
              if (last_word_s) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                state_r    <= CHECK;
`else
                state_r    <= DONE;
                in_ready_r <= 1'b0;
`endif
              end
            end
          end
        end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        CHECK: begin
          if (xfer_s) begin
            in_ready_r <= 1'b0;
            if (bus.in_data == csum_r) begin
              state_r     <= DONE;
              done_r      <= 1'b1;
              cpu_reset_r <= 1'b0;
            end else begin
              state_r <= ERROR;
              error_r <= 1'b1;
            end
          end
        end
`endif
        DONE: begin
          in_ready_r  <= 1'b0;
          done_r      <= 1'b1;
          cpu_reset_r <= 1'b0;
        end
        ERROR: begin
          in_ready_r  <= 1'b0;
          error_r     <= 1'b1;
          cpu_reset_r <= 1'b1;
        end
        default: begin
          state_r     <= ERROR;
          in_ready_r  <= 1'b0;
          cpu_reset_r <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign cpu_reset     = cpu_reset_r;
  assign done          = done_r;
  assign error         = error_r;
  assign words_loaded  = words_loaded_r;

endmodule
